// File: rtl/alu_regfile_core.sv
// alu_regfile_core: 8 x 16 register file (two combinational read ports, one
// synchronous write port addressed by port A) feeding a combinational ALU.
module alu_regfile_core #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            opcode,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  zero
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int SHAMT_W  = $clog2(DATA_WIDTH);

  localparam logic [3:0] OP_PASSB = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_XOR   = 4'b0110;
  localparam logic [3:0] OP_NOT   = 4'b0111;
  localparam logic [3:0] OP_SHL   = 4'b1000;
  localparam logic [3:0] OP_SHR   = 4'b1001;
  localparam logic [3:0] OP_SLT   = 4'b1010;
  localparam logic [3:0] OP_PASSA = 4'b1111;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // One storage word per register; the write port shares address_a with read port A.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    // Next value: take write_data when this entry is the write target, else hold.
    assign regs_d[gi] = (write_enable && (address_a == ADDR_WIDTH'(gi))) ? write_data : regs_q[gi];

    // Register update; reset clears the entry and wins over a same-cycle write.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        regs_q[gi] <= '0;
      end else begin
        regs_q[gi] <= regs_d[gi];
      end
    end
  end

  // Reads come straight from storage, so a write only becomes visible after its edge.
  assign data_a = regs_q[address_a];
  assign data_b = regs_q[address_b];

  logic slt;
  assign slt = ($signed(data_a) < $signed(data_b));

  // ALU: shifts use only the low bits of B; unassigned opcodes produce zero.
  always_comb begin
    alu_result = '0;
    case (opcode)
      OP_PASSB: alu_result = data_b;
      OP_ADD:   alu_result = data_a + data_b;
      OP_SUB:   alu_result = data_a - data_b;
      OP_AND:   alu_result = data_a & data_b;
      OP_OR:    alu_result = data_a | data_b;
      OP_XOR:   alu_result = data_a ^ data_b;
      OP_NOT:   alu_result = ~data_a;
      OP_SHL:   alu_result = data_a << data_b[SHAMT_W-1:0];
      OP_SHR:   alu_result = data_a >> data_b[SHAMT_W-1:0];
      OP_SLT:   alu_result = {{(DATA_WIDTH-1){1'b0}}, slt};
      OP_PASSA: alu_result = data_a;
      default:  alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

endmodule

// File: tb/tb_alu_regfile_core.sv
// tb_alu_regfile_core: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_alu_regfile_core;

  logic        clk;
  logic        rst_n;
  logic [3:0]  opcode;
  logic [2:0]  address_a;
  logic [2:0]  address_b;
  logic        write_enable;
  logic [15:0] write_data;
  logic [15:0] data_a;
  logic [15:0] data_b;
  logic [15:0] alu_result;
  logic        zero;

  int tests = 0;
  int fails = 0;
  bit check_en = 0;

  logic [15:0] model_regs [8];

  alu_regfile_core dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .address_a(address_a), .address_b(address_b),
    .write_enable(write_enable), .write_data(write_data),
    .data_a(data_a), .data_b(data_b),
    .alu_result(alu_result), .zero(zero)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference ALU written straight from the operation table.
  function automatic logic [15:0] alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      4'd1:  return b;
      4'd2:  return 16'((int'(a) + int'(b)) % 65536);
      4'd3:  return 16'((int'(a) - int'(b) + 65536) % 65536);
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return a ^ b;
      4'd7:  return 16'hFFFF - a;
      4'd8:  return 16'((int'(a) * (1 << (b % 16))) % 65536);
      4'd9:  return 16'(int'(a) / (1 << (b % 16)));
      4'd10: return (sa < sb) ? 16'd1 : 16'd0;
      4'd15: return a;
      default: return 16'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Register-file model: reset clears everything, otherwise a strobed write lands.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) model_regs[i] = 16'h0;
    end else if (write_enable) begin
      model_regs[address_a] = write_data;
    end
  end

  // Every cycle, mid-period, compare all outputs with the model.
  always @(negedge clk) begin
    if (check_en) begin
      logic [15:0] ea, eb, er;
      ea = model_regs[address_a];
      eb = model_regs[address_b];
      er = alu_model(opcode, ea, eb);
      check("model_data_a", data_a, ea);
      check("model_data_b", data_b, eb);
      check("model_alu_result", alu_result, er);
      check("model_zero", {15'h0, zero}, {15'h0, (er == 16'h0)});
      $display("[TB] t=%0t rst_n=%0b op=%h a=%0d b=%0d we=%0b wd=%h -> da=%h db=%h res=%h z=%0b",
               $time, rst_n, opcode, address_a, address_b, write_enable, write_data,
               data_a, data_b, alu_result, zero);
    end
  end

  // Apply one cycle of inputs just after a rising edge, then return at the falling edge.
  task automatic drive(input logic r, input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                       input logic we, input logic [15:0] wd);
    @(posedge clk);
    #1;
    rst_n = r; opcode = op; address_a = a; address_b = b;
    write_enable = we; write_data = wd;
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] wd);
    drive(1'b1, 4'd15, a, 3'd0, 1'b1, wd);
  endtask

  initial begin
    rst_n = 0; opcode = 4'd2; address_a = 0; address_b = 0;
    write_enable = 1; write_data = 16'hFFFF;

    // Reset with a write pending: write must be dropped.
    @(posedge clk);
    #1;
    check_en = 1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'd2, 3'(i), 3'(7 - i), 1'b0, 16'h0);
      check("reset_reg", data_a, 16'h0000);
      check("reset_zero_add", {15'h0, zero}, 16'h0001);
    end

    // Write/read, including old value before the write edge.
    drive(1'b1, 4'd15, 3'd3, 3'd0, 1'b1, 16'h1234);
    check("pre_write_old", data_a, 16'h0000);
    wr(3'd5, 16'h0F0F);
    drive(1'b1, 4'd15, 3'd3, 3'd5, 1'b0, 16'h0);
    check("rd_r3", data_a, 16'h1234);
    check("rd_r5", data_b, 16'h0F0F);

    // Arithmetic wrap and signed compare.
    wr(3'd3, 16'hFFFF);
    wr(3'd5, 16'h0001);
    drive(1'b1, 4'd2, 3'd3, 3'd5, 1'b0, 16'h0);
    check("add_wrap", alu_result, 16'h0000);
    check("add_wrap_zero", {15'h0, zero}, 16'h0001);
    drive(1'b1, 4'd3, 3'd3, 3'd5, 1'b0, 16'h0);
    check("sub", alu_result, 16'hFFFE);
    check("sub_zero", {15'h0, zero}, 16'h0000);
    drive(1'b1, 4'd10, 3'd3, 3'd5, 1'b0, 16'h0);
    check("slt_signed", alu_result, 16'h0001);

    // Equal operands subtract to zero.
    wr(3'd1, 16'h00AA);
    wr(3'd2, 16'h00AA);
    drive(1'b1, 4'd3, 3'd1, 3'd2, 1'b0, 16'h0);
    check("sub_eq", alu_result, 16'h0000);
    check("sub_eq_zero", {15'h0, zero}, 16'h0001);

    // Logic and shifts.
    wr(3'd6, 16'hF0F0);
    wr(3'd7, 16'h0004);
    wr(3'd4, 16'h0014);
    drive(1'b1, 4'd4, 3'd6, 3'd7, 1'b0, 16'h0);  check("and", alu_result, 16'h0000);
    drive(1'b1, 4'd5, 3'd6, 3'd7, 1'b0, 16'h0);  check("or", alu_result, 16'hF0F4);
    drive(1'b1, 4'd6, 3'd6, 3'd7, 1'b0, 16'h0);  check("xor", alu_result, 16'hF0F4);
    drive(1'b1, 4'd7, 3'd6, 3'd7, 1'b0, 16'h0);  check("not", alu_result, 16'h0F0F);
    drive(1'b1, 4'd8, 3'd6, 3'd7, 1'b0, 16'h0);  check("shl", alu_result, 16'h0F00);
    drive(1'b1, 4'd9, 3'd6, 3'd7, 1'b0, 16'h0);  check("shr", alu_result, 16'h0F0F);
    drive(1'b1, 4'd8, 3'd6, 3'd4, 1'b0, 16'h0);  check("shl_b_low4", alu_result, 16'h0F00);
    drive(1'b1, 4'd9, 3'd6, 3'd4, 1'b0, 16'h0);  check("shr_b_low4", alu_result, 16'h0F0F);
    drive(1'b1, 4'd1, 3'd6, 3'd6, 1'b0, 16'h0);  check("same_reg_b", data_b, 16'hF0F0);
    drive(1'b1, 4'd0, 3'd6, 3'd7, 1'b0, 16'h0);  check("undef_op", alu_result, 16'h0000);
    check("undef_zero", {15'h0, zero}, 16'h0001);

    // Reset mid-operation drops the pending write.
    drive(1'b0, 4'd15, 3'd3, 3'd6, 1'b1, 16'h5555);
    drive(1'b1, 4'd15, 3'd3, 3'd6, 1'b0, 16'h0);
    check("midrst_r3", data_a, 16'h0000);
    check("midrst_r6", data_b, 16'h0000);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] op;
      logic [15:0] wd;
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: wd = 16'($urandom);
        1: wd = 16'($urandom_range(0, 20));
        2: wd = 16'hFFFF - 16'($urandom_range(0, 3));
        default: wd = 16'h8000 ^ 16'($urandom_range(0, 3));
      endcase
      drive(($urandom_range(0, 49) != 0), op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), wd);
    end

    @(posedge clk);
    #1;
    check_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
